rv_ifetch: RTL and testbench

Instruction-fetch stage of the pipelined RV32I core and the producer of every instruction word the decode stage consumes. Maintains the fetch PC, issues word requests to instruction memory, buffers in-order responses in a small prefetch FIFO, and presents {instr, pc, pc+4} to decode over a valid/ready handshake. Taken branches, JAL and JALR from EX redirect the fetch stream; in-flight responses to the old stream are discarded.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/rv_sync_fifo.sv | 63 ++++++
 rtl/rv_ifetch.sv | 144 ++++++++++++++
 tb/tb_rv_ifetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared types and constants for the RV32I instruction-fetch stage.
//   if_state_e : fetch controller states
//   if_entry_t : one prefetch entry, instruction word plus its PC
//   INSTR_NOP  : canonical NOP (ADDI x0,x0,0) shown when nothing is valid
package rv_pkg;

   typedef enum logic [1:0] {
      IF_RESET = 2'd0,
      IF_RUN   = 2'd1,
      IF_DRAIN = 2'd2
   } if_state_e;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } if_entry_t;

   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/rv_sync_fifo.sv
// Single-clock FIFO with registered storage and a head that reads straight
// out of the storage array, so an entry written at an edge is visible on
// head right after that edge.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write an entry (accepted when not full, or when full
//                     and popping in the same cycle)
//   pop             : remove the head entry (ignored when empty)
//   flush           : discard all entries; overrides push and pop
//   head            : oldest entry
//   count           : number of entries held
//   full, empty     : occupancy flags
module rv_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rv_ifetch.sv
// Instruction-fetch stage: keeps the fetch PC, issues word requests to
// instruction memory, buffers in-order responses in a prefetch FIFO and
// hands {instr, pc, pc+4} to decode over valid/ready. EX redirects restart
// the stream and discard responses still in flight for the old one.
//   i_clk, i_rst                  : clock, asynchronous active-high reset
//   o_imem_req/addr, i_imem_gnt   : request channel (issue = req && gnt)
//   i_imem_rvalid/rdata           : in-order response channel
//   i_redirect_valid/pc           : EX redirect (branch, JAL, JALR)
//   o_if_valid, i_if_ready        : decode handshake
//   o_if_instr/pc/pc_plus_4       : decode payload (NOP, 0, 4 when idle)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IF_RESET | held in reset and for one cycle after release; no requests
// IF_RUN   | normal fetching, every response is kept
// IF_DRAIN | stale responses still due; drop_cnt of them get discarded
module rv_ifetch
   import rv_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_gnt,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
   input  logic        i_redirect_valid,
   input  logic [31:0] i_redirect_pc,
   output logic        o_if_valid,
   input  logic        i_if_ready,
   output logic [31:0] o_if_instr,
   output logic [31:0] o_if_pc,
   output logic [31:0] o_if_pc_plus_4
);

   localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

   if_state_e     state;
   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] drop_next;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] tag_count;
   logic [CW:0]   credit_used;
   logic          issue;
   logic          resp_keep;
   logic          if_pop;
   logic          fifo_empty;
   logic          fifo_full;
   logic          tag_full;
   logic          tag_empty;
   logic [31:0]   tag_pc;
   if_entry_t     push_entry;
   if_entry_t     head_entry;
   logic          unused_ok;

   // Outstanding requests reserve FIFO space, so a response always fits.
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign o_imem_req  = (state != IF_RESET) && !i_redirect_valid && (credit_used < CREDITS);
   assign o_imem_addr = fetch_pc;
   assign issue       = o_imem_req && i_imem_gnt;

   // A response arriving with a redirect belongs to the old stream.
   assign resp_keep  = i_imem_rvalid && (drop_cnt == '0) && !i_redirect_valid;
   assign if_pop     = o_if_valid && i_if_ready;
   assign push_entry = '{instr: i_imem_rdata, pc: tag_pc};

   always_comb begin
      drop_next = drop_cnt;
      if (i_redirect_valid)
         drop_next = outstanding - CW'(i_imem_rvalid);
      else if (i_imem_rvalid && (drop_cnt != '0))
         drop_next = drop_cnt - 1'b1;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state       <= IF_RESET;
         fetch_pc    <= {RESET_PC[31:2], 2'b00};
         outstanding <= '0;
         drop_cnt    <= '0;
      end else begin
         outstanding <= outstanding + CW'(issue) - CW'(i_imem_rvalid);
         drop_cnt    <= drop_next;
         if (i_redirect_valid)
            fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         else if (issue)
            fetch_pc <= fetch_pc + 32'd4;
         case (state)
            IF_RESET: state <= IF_RUN;
            IF_RUN,
            IF_DRAIN: state <= (drop_next != '0) ? IF_DRAIN : IF_RUN;
            default:  state <= IF_RESET;
         endcase
      end
   end

   // PC tags of live requests; stale tags are flushed on redirect and the
   // matching stale responses never pop here because drop_cnt covers them.
   rv_sync_fifo #(
      .WIDTH (32),
      .DEPTH (FIFO_DEPTH)
   ) u_tag_q (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (issue),
      .push_data (fetch_pc),
      .pop       (resp_keep),
      .flush     (i_redirect_valid),
      .head      (tag_pc),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   rv_sync_fifo #(
      .WIDTH ($bits(if_entry_t)),
      .DEPTH (FIFO_DEPTH)
   ) u_prefetch (
      .clk       (i_clk),
      .rst       (i_rst),
      .push      (resp_keep),
      .push_data (push_entry),
      .pop       (if_pop),
      .flush     (i_redirect_valid),
      .head      (head_entry),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign o_if_valid     = !fifo_empty;
   assign o_if_instr     = o_if_valid ? head_entry.instr : INSTR_NOP;
   assign o_if_pc        = o_if_valid ? head_entry.pc : 32'h0;
   assign o_if_pc_plus_4 = o_if_pc + 32'd4;

   assign unused_ok = ^{fifo_full, tag_full, tag_empty, tag_count, i_redirect_pc[1:0]};

endmodule

// File: tb/tb_rv_ifetch.sv
module tb_rv_ifetch;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        gnt = 1'b1;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = 32'h0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        ready = 1'b1;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [31:0] if_pc4;

   rv_ifetch #(.RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .o_imem_req       (imem_req),
      .o_imem_addr      (imem_addr),
      .i_imem_gnt       (gnt),
      .i_imem_rvalid    (rvalid),
      .i_imem_rdata     (rdata),
      .i_redirect_valid (redirect),
      .i_redirect_pc    (redirect_pc),
      .o_if_valid       (if_valid),
      .i_if_ready       (ready),
      .o_if_instr       (if_instr),
      .o_if_pc          (if_pc),
      .o_if_pc_plus_4   (if_pc4)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] iss_q[$];
   if_entry_t   pop_q[$];
   int          cyc = 0;
   int          mem_lat = 1;
   logic [31:0] resp_addr = 32'h0;
   int          vecs = 0;
   int          errs = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
   endfunction

   // Memory model and handshake logger; inputs change only at negedge,
   // so everything is settled one time unit later.
   initial begin : mem_model
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            mq.delete();
            rvalid = 1'b0;
         end else begin
            if (if_valid && ready && !redirect)
               pop_q.push_back('{instr: if_instr, pc: if_pc});
            if (mq.size() > 0 && mq[0].due <= cyc) begin
               rvalid    = 1'b1;
               resp_addr = mq[0].addr;
               rdata     = mem_word(mq[0].addr);
               void'(mq.pop_front());
            end else begin
               rvalid = 1'b0;
            end
            if (imem_req && gnt) begin
               iss_q.push_back(imem_addr);
               mq.push_back('{addr: imem_addr, due: cyc + mem_lat});
            end
         end
         cyc++;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      redirect = 1'b0;
      repeat (2) @(negedge clk);
      iss_q.delete();
      pop_q.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      #2;
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req: got %b expected 0", imem_req); end
      vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rst_addr: got %h expected 00000100", imem_addr); end
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL rst_valid: got %b expected 0", if_valid); end
      vecs++; if (if_instr !== 32'h13) begin errs++; $display("FAIL rst_instr: got %h expected 00000013", if_instr); end
      vecs++; if (if_pc !== 32'h0) begin errs++; $display("FAIL rst_pc: got %h expected 00000000", if_pc); end
      vecs++; if (if_pc4 !== 32'h4) begin errs++; $display("FAIL rst_pc4: got %h expected 00000004", if_pc4); end
      @(negedge clk);
      rst = 1'b0;
      #2;
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rel_req0: got %b expected 0", imem_req); end
      @(negedge clk);
      #2;
      vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL rel_req1: got %b expected 1", imem_req); end
      vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rel_addr: got %h expected 00000100", imem_addr); end
   endtask

   task automatic test_stream();
      logic        prev_rv;
      logic [31:0] prev_addr;
      mem_lat = 1;
      ready   = 1'b1;
      do_reset();
      prev_rv   = 1'b0;
      prev_addr = 32'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         #2;
         if (prev_rv) begin
            vecs++; if (if_valid !== 1'b1 || if_pc !== prev_addr) begin errs++; $display("FAIL stream_track: got valid=%b pc=%h expected valid=1 pc=%h", if_valid, if_pc, prev_addr); end
            vecs++; if (if_instr !== mem_word(prev_addr)) begin errs++; $display("FAIL stream_instr: got %h expected %h", if_instr, mem_word(prev_addr)); end
            vecs++; if (if_pc4 !== prev_addr + 32'd4) begin errs++; $display("FAIL stream_pc4: got %h expected %h", if_pc4, prev_addr + 32'd4); end
         end
         prev_rv   = rvalid;
         prev_addr = resp_addr;
      end
      vecs++;
      if (iss_q.size() < 3 || pop_q.size() < 3) begin
         errs++; $display("FAIL stream_count: got issued=%0d popped=%0d expected at least 3 each", iss_q.size(), pop_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            vecs++; if (iss_q[i] !== 32'h100 + 32'(4 * i)) begin errs++; $display("FAIL stream_addr%0d: got %h expected %h", i, iss_q[i], 32'h100 + 32'(4 * i)); end
            vecs++; if (pop_q[i].pc !== 32'h100 + 32'(4 * i)) begin errs++; $display("FAIL stream_pop%0d: got %h expected %h", i, pop_q[i].pc, 32'h100 + 32'(4 * i)); end
         end
      end
   endtask

   task automatic test_backpressure();
      mem_lat = 1;
      ready   = 1'b0;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #2;
         vecs++; if (iss_q.size() > 2) begin errs++; $display("FAIL bp_issued: got %0d expected <= 2", iss_q.size()); end
      end
      vecs++; if (iss_q.size() !== 2) begin errs++; $display("FAIL bp_issued_final: got %0d expected 2", iss_q.size()); end
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL bp_req: got %b expected 0", imem_req); end
      vecs++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin errs++; $display("FAIL bp_head: got valid=%b pc=%h expected valid=1 pc=00000100", if_valid, if_pc); end
      @(negedge clk);
      ready = 1'b1;
      repeat (10) @(negedge clk);
      #2;
      vecs++; if (pop_q.size() < 4) begin errs++; $display("FAIL bp_popcount: got %0d expected >= 4", pop_q.size()); end
      for (int i = 0; i < pop_q.size(); i++) begin
         vecs++;
         if (pop_q[i].pc !== 32'h100 + 32'(4 * i) || pop_q[i].instr !== mem_word(32'h100 + 32'(4 * i))) begin
            errs++; $display("FAIL bp_order%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, pop_q[i].pc, pop_q[i].instr, 32'h100 + 32'(4 * i), mem_word(32'h100 + 32'(4 * i)));
         end
      end
   endtask

   task automatic test_redirect_drop();
      mem_lat = 3;
      ready   = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h400;
      #2;
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL drop_req_redir: got %b expected 0", imem_req); end
      vecs++; if (iss_q.size() !== 2) begin errs++; $display("FAIL drop_outstanding: got %0d expected 2", iss_q.size()); end
      @(negedge clk);
      redirect = 1'b0;
      #2;
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL drop_valid_after: got %b expected 0", if_valid); end
      repeat (12) @(negedge clk);
      #2;
      vecs++;
      if (pop_q.size() == 0) begin
         errs++; $display("FAIL drop_first: got no output expected pc=00000400");
      end else if (pop_q[0].pc !== 32'h400 || pop_q[0].instr !== mem_word(32'h400)) begin
         errs++; $display("FAIL drop_first: got pc=%h instr=%h expected pc=00000400 instr=%h", pop_q[0].pc, pop_q[0].instr, mem_word(32'h400));
      end
      vecs++;
      if (iss_q.size() < 3 || iss_q[2] !== 32'h400) begin
         errs++; $display("FAIL drop_target_addr: got size=%0d expected third issue 00000400", iss_q.size());
      end
   endtask

   task automatic test_redirect_same_rvalid();
      mem_lat = 2;
      ready   = 1'b1;
      do_reset();
      repeat (2) @(negedge clk);
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h203;
      @(negedge clk);
      redirect = 1'b0;
      #2;
      vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL same_req: got %b expected 1", imem_req); end
      vecs++; if (imem_addr !== 32'h200) begin errs++; $display("FAIL same_addr: got %h expected 00000200", imem_addr); end
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL same_valid: got %b expected 0", if_valid); end
      repeat (10) @(negedge clk);
      #2;
      vecs++;
      if (pop_q.size() < 2) begin
         errs++; $display("FAIL same_popcount: got %0d expected >= 2", pop_q.size());
      end else if (pop_q[0].pc !== 32'h200 || pop_q[1].pc !== 32'h204) begin
         errs++; $display("FAIL same_order: got %h,%h expected 00000200,00000204", pop_q[0].pc, pop_q[1].pc);
      end
   endtask

   task automatic test_wrap();
      logic seen;
      mem_lat = 1;
      ready   = 1'b1;
      do_reset();
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect = 1'b0;
      #2;
      vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         #2;
         if (if_valid && if_pc == 32'hFFFF_FFFC) begin
            seen = 1'b1;
            vecs++; if (if_pc4 !== 32'h0) begin errs++; $display("FAIL wrap_pc4: got %h expected 00000000", if_pc4); end
         end
      end
      vecs++; if (seen !== 1'b1) begin errs++; $display("FAIL wrap_seen: got %b expected 1", seen); end
      vecs++;
      if (iss_q.size() < 2 || iss_q[0] !== 32'hFFFF_FFFC || iss_q[1] !== 32'h0) begin
         errs++; $display("FAIL wrap_next: got size=%0d expected fffffffc then 00000000", iss_q.size());
      end
      vecs++;
      if (pop_q.size() < 2 || pop_q[1].pc !== 32'h0) begin
         errs++; $display("FAIL wrap_pop: got size=%0d expected second pc 00000000", pop_q.size());
      end
   endtask

   task automatic test_reset_midstream();
      mem_lat = 1;
      ready   = 1'b0;
      do_reset();
      repeat (6) @(negedge clk);
      #2;
      vecs++; if (if_valid !== 1'b1) begin errs++; $display("FAIL mid_prefill: got %b expected 1", if_valid); end
      @(negedge clk);
      rst = 1'b1;
      #2;
      vecs++; if (if_valid !== 1'b0) begin errs++; $display("FAIL mid_valid: got %b expected 0", if_valid); end
      vecs++; if (if_instr !== 32'h13) begin errs++; $display("FAIL mid_instr: got %h expected 00000013", if_instr); end
      vecs++; if (if_pc !== 32'h0 || if_pc4 !== 32'h4) begin errs++; $display("FAIL mid_pc: got %h/%h expected 00000000/00000004", if_pc, if_pc4); end
      vecs++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errs++; $display("FAIL mid_req: got req=%b addr=%h expected req=0 addr=00000100", imem_req, imem_addr); end
      repeat (2) @(negedge clk);
      rst   = 1'b0;
      ready = 1'b1;
      #2;
      vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL mid_rel0: got %b expected 0", imem_req); end
      @(negedge clk);
      #2;
      vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL mid_rel1: got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_drop();
      test_redirect_same_rvalid();
      test_wrap();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
